mram_ctrl: RTL and testbench

- Sequences the off-chip MRAM interface (maddr, mdata, webar, rebar) behind the pad drivers.
- Shares that interface between two requesters: port 0 is the SPI programmer/loader, port 1 is the processor core memory port.
- Generates parameterised read and write strobe timing and controls the mdata pad output enable.
- Owns the bidirectional data-bus turnaround.

---
 rtl/mram_ctrl_if.sv | 38 +++
 rtl/mram_ctrl.sv | 122 ++++++++++++
 tb/tb_mram_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mram_ctrl_if.sv
// Requester ports and MRAM pad signals of the shared MRAM controller.
// The controller uses the slave view; the requesters and pad side use the master view.
interface mram_ctrl_if;
    logic        PROGRAM;
    logic        p0_req;
    logic        p0_we;
    logic [15:0] p0_addr;
    logic [31:0] p0_wdata;
    logic        p0_ack;
    logic [31:0] p0_rdata;
    logic        p1_req;
    logic        p1_we;
    logic [15:0] p1_addr;
    logic [31:0] p1_wdata;
    logic        p1_ack;
    logic [31:0] p1_rdata;
    logic        busy;
    logic [15:0] maddr_chip;
    logic [31:0] mwd_chip;
    logic [31:0] mrd_chip;
    logic        mdata_oe_chip;
    logic        webar_chip;
    logic        rebar_chip;

    modport master (
        output PROGRAM, p0_req, p0_we, p0_addr, p0_wdata,
               p1_req, p1_we, p1_addr, p1_wdata, mrd_chip,
        input  p0_ack, p0_rdata, p1_ack, p1_rdata, busy,
               maddr_chip, mwd_chip, mdata_oe_chip, webar_chip, rebar_chip
    );

    modport slave (
        input  PROGRAM, p0_req, p0_we, p0_addr, p0_wdata,
               p1_req, p1_we, p1_addr, p1_wdata, mrd_chip,
        output p0_ack, p0_rdata, p1_ack, p1_rdata, busy,
               maddr_chip, mwd_chip, mdata_oe_chip, webar_chip, rebar_chip
    );
endinterface

// File: rtl/mram_ctrl.sv
// Two-port round-robin MRAM sequencer: arbitrates in IDLE, then runs a timed
// read or write strobe sequence with registered pad controls and bus turnaround.
module mram_ctrl #(
    parameter int RD_CYCLES = 2,
    parameter int WR_SETUP  = 1,
    parameter int WR_PULSE  = 2,
    parameter int WR_HOLD   = 1
) (
    input  logic       clk,
    input  logic       areset,
    mram_ctrl_if.slave bus
);
    localparam int MAX_RW  = (RD_CYCLES > WR_PULSE) ? RD_CYCLES : WR_PULSE;
    localparam int MAX_SH  = (WR_SETUP > WR_HOLD) ? WR_SETUP : WR_HOLD;
    localparam int MAX_CYC = (MAX_RW > MAX_SH) ? MAX_RW : MAX_SH;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [2:0] {IDLE, RD, WSU, WP, WH, ACK} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             ptr, owner, we_r;
    logic [15:0]      maddr;
    logic [31:0]      mwd, rdata0, rdata1;
    logic             webar, rebar, oe, ack0, ack1;
    logic             elig0, elig1, grant, capture;
    logic             gnt_port, gnt_we;
    logic [15:0]      gnt_addr;
    logic [31:0]      gnt_wdata;

    // Counter preload is dwell-1 so a state ends on the edge where cnt is zero.
    function automatic logic [CNT_W-1:0] dwell(input state_t s);
        case (s)
            RD:      dwell = CNT_W'(RD_CYCLES - 1);
            WSU:     dwell = CNT_W'(WR_SETUP - 1);
            WP:      dwell = CNT_W'(WR_PULSE - 1);
            WH:      dwell = CNT_W'(WR_HOLD - 1);
            default: dwell = '0;
        endcase
    endfunction

    assign elig0     = bus.p0_req;
    assign elig1     = bus.p1_req && !bus.PROGRAM;
    assign gnt_port  = (elig0 && elig1) ? ptr : elig1;
    assign gnt_we    = gnt_port ? bus.p1_we    : bus.p0_we;
    assign gnt_addr  = gnt_port ? bus.p1_addr  : bus.p0_addr;
    assign gnt_wdata = gnt_port ? bus.p1_wdata : bus.p0_wdata;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        grant   = 1'b0;
        case (state)
            IDLE: if (elig0 || elig1) begin
                grant   = 1'b1;
                state_n = gnt_we ? WSU : RD;
            end
            RD:      if (cnt == '0) state_n = ACK;
            WSU:     if (cnt == '0) state_n = WP;
            WP:      if (cnt == '0) state_n = WH;
            WH:      if (cnt == '0) state_n = ACK;
            ACK:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (state_n != state)
            cnt_n = dwell(state_n);
        else if (cnt != '0)
            cnt_n = cnt - CNT_W'(1);
    end

    assign capture = (state == RD) && (state_n == ACK) && !we_r;

    // Pad controls are registered from the next state so they change on the state edge.
    always_ff @(posedge clk) begin
        if (areset) begin
            state  <= IDLE;
            cnt    <= '0;
            ptr    <= 1'b0;
            owner  <= 1'b0;
            we_r   <= 1'b0;
            maddr  <= '0;
            mwd    <= '0;
            rdata0 <= '0;
            rdata1 <= '0;
            webar  <= 1'b1;
            rebar  <= 1'b1;
            oe     <= 1'b1;
            ack0   <= 1'b0;
            ack1   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            webar <= (state_n != WP);
            rebar <= (state_n != RD);
            oe    <= !(state_n inside {WSU, WP, WH});
            ack0  <= (state_n == ACK) && !owner;
            ack1  <= (state_n == ACK) && owner;
            if (grant) begin
                owner <= gnt_port;
                we_r  <= gnt_we;
                maddr <= gnt_addr;
                mwd   <= gnt_wdata;
                ptr   <= !gnt_port;
            end
            if (capture) begin
                if (owner) rdata1 <= bus.mrd_chip;
                else       rdata0 <= bus.mrd_chip;
            end
        end
    end

    assign bus.busy          = (state != IDLE);
    assign bus.maddr_chip    = maddr;
    assign bus.mwd_chip      = mwd;
    assign bus.webar_chip    = webar;
    assign bus.rebar_chip    = rebar;
    assign bus.mdata_oe_chip = oe;
    assign bus.p0_ack        = ack0;
    assign bus.p1_ack        = ack1;
    assign bus.p0_rdata      = rdata0;
    assign bus.p1_rdata      = rdata1;
endmodule

// File: tb/tb_mram_ctrl.sv
// Bench for mram_ctrl: transaction-timeline model compared every cycle,
// plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_mram_ctrl;
    localparam int RD = 2;
    localparam int WS = 1;
    localparam int WP = 2;
    localparam int WH = 1;

    logic clk = 1'b0;
    logic areset;
    always #5 clk = ~clk;

    mram_ctrl_if bus();
    mram_ctrl #(.RD_CYCLES(RD), .WR_SETUP(WS), .WR_PULSE(WP), .WR_HOLD(WH))
        dut (.clk(clk), .areset(areset), .bus(bus));

    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] rd_val(input logic [15:0] a);
        return (a == 16'h0010) ? 32'hDEADBEEF : {a ^ 16'hC3C3, a};
    endfunction

    // MRAM pad: drives data only while the read strobe is low.
    assign bus.mrd_chip = bus.rebar_chip ? 32'h0 : rd_val(bus.maddr_chip);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'b0, act}, {31'b0, exp});
    endtask

    // Model: a granted transaction is a timeline indexed by cycle k after the grant edge.
    logic        m_act = 1'b0;
    int          m_k = 0;
    logic        m_own = 1'b0, m_we = 1'b0, m_ptr = 1'b0;
    logic [15:0] m_addr = '0;
    logic [31:0] m_wdata = '0, m_rd0 = '0, m_rd1 = '0;
    int          m_acks = 0;
    int          m_len;
    logic        m_e0, m_e1, m_g;

    assign m_e0 = bus.p0_req;
    assign m_e1 = bus.p1_req & ~bus.PROGRAM;
    assign m_g  = (m_e0 & m_e1) ? m_ptr : m_e1;
    always_comb m_len = m_we ? (WS + WP + WH + 1) : (RD + 1);

    always @(posedge clk) begin
        if (areset) begin
            m_act   <= 1'b0;
            m_k     <= 0;
            m_ptr   <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_rd0   <= '0;
            m_rd1   <= '0;
        end else if (!m_act) begin
            if (m_e0 || m_e1) begin
                m_act   <= 1'b1;
                m_k     <= 0;
                m_own   <= m_g;
                m_we    <= m_g ? bus.p1_we : bus.p0_we;
                m_addr  <= m_g ? bus.p1_addr : bus.p0_addr;
                m_wdata <= m_g ? bus.p1_wdata : bus.p0_wdata;
                m_ptr   <= !m_g;
            end
        end else if (m_k == m_len - 1) begin
            m_act <= 1'b0;
        end else begin
            m_k <= m_k + 1;
            if (m_k + 1 == m_len - 1) m_acks <= m_acks + 1;
            if (!m_we && m_k + 1 == RD) begin
                if (m_own) m_rd1 <= rd_val(m_addr);
                else       m_rd0 <= rd_val(m_addr);
            end
        end
    end

    bit chk_on   = 1'b0;
    int dut_acks = 0;

    always @(negedge clk) begin
        if (chk_on) begin
            chk1("busy",  bus.busy, m_act);
            chk1("rebar", bus.rebar_chip, !(m_act && !m_we && m_k < RD));
            chk1("webar", bus.webar_chip, !(m_act && m_we && m_k >= WS && m_k < WS + WP));
            chk1("oe",    bus.mdata_oe_chip, !(m_act && m_we && m_k < WS + WP + WH));
            chk1("ack0",  bus.p0_ack, m_act && (m_k == m_len - 1) && !m_own);
            chk1("ack1",  bus.p1_ack, m_act && (m_k == m_len - 1) && m_own);
            chk("maddr",  {16'b0, bus.maddr_chip}, {16'b0, m_addr});
            chk("mwd",    bus.mwd_chip, m_wdata);
            chk("rdata0", bus.p0_rdata, m_rd0);
            chk("rdata1", bus.p1_rdata, m_rd1);
            chk1("strobe_overlap", bus.webar_chip | bus.rebar_chip, 1'b1);
            chk1("read_while_driving", !bus.rebar_chip && !bus.mdata_oe_chip, 1'b0);
            dut_acks <= dut_acks + int'(bus.p0_ack) + int'(bus.p1_ack);
        end
    end

    task automatic run_txn(input bit port, input bit we, input logic [15:0] a, input logic [31:0] d,
                           output int ack_cyc, output int rd_lo, output int oe_lo, output int oe_first,
                           output int wr_lo, output int wr_first, output bit stable);
        ack_cyc = -1; rd_lo = 0; oe_lo = 0; oe_first = -1; wr_lo = 0; wr_first = -1; stable = 1'b1;
        if (port) begin
            bus.p1_req = 1'b1; bus.p1_we = we; bus.p1_addr = a; bus.p1_wdata = d;
        end else begin
            bus.p0_req = 1'b1; bus.p0_we = we; bus.p0_addr = a; bus.p0_wdata = d;
        end
        for (int c = 2; c <= 40 && ack_cyc < 0; c++) begin
            @(negedge clk);
            if (!bus.rebar_chip) rd_lo++;
            if (!bus.mdata_oe_chip) begin
                oe_lo++;
                if (oe_first < 0) oe_first = c;
                if (bus.maddr_chip !== a || bus.mwd_chip !== d) stable = 1'b0;
            end
            if (!bus.webar_chip) begin
                wr_lo++;
                if (wr_first < 0) wr_first = c;
            end
            if ((port ? bus.p1_ack : bus.p0_ack) === 1'b1) ack_cyc = c;
        end
        bus.p0_req = 1'b0;
        bus.p1_req = 1'b0;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        repeat (2) @(negedge clk);
        areset = 1'b0;
    endtask

    initial begin
        int ack_cyc, rd_lo, oe_lo, oe_first, wr_lo, wr_first;
        bit stable, found, prev_ack;
        int busy_cnt, ack_cnt;
        int order[$];

        areset = 1'b1;
        bus.PROGRAM = 1'b0;
        bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
        bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_webar", bus.webar_chip, 1'b1);
        chk1("rst_rebar", bus.rebar_chip, 1'b1);
        chk1("rst_oe", bus.mdata_oe_chip, 1'b1);
        chk("rst_maddr", {16'b0, bus.maddr_chip}, 32'h0);
        chk("rst_rdata0", bus.p0_rdata, 32'h0);
        areset = 1'b0;
        @(negedge clk);

        // p0 read
        run_txn(1'b0, 1'b0, 16'h0010, 32'h0, ack_cyc, rd_lo, oe_lo, oe_first, wr_lo, wr_first, stable);
        chk("t1_ack_cycle", ack_cyc, 32'd4);
        chk("t1_rebar_low", rd_lo, 32'd2);
        chk("t1_rdata", bus.p0_rdata, 32'hDEADBEEF);
        @(negedge clk);
        chk1("t1_ack_single", bus.p0_ack, 1'b0);
        chk1("t1_turnaround", bus.busy, 1'b0);

        // p1 write
        run_txn(1'b1, 1'b1, 16'h1234, 32'hA5A5A5A5, ack_cyc, rd_lo, oe_lo, oe_first, wr_lo, wr_first, stable);
        chk("t2_oe_low", oe_lo, 32'd4);
        chk("t2_oe_first", oe_first, 32'd2);
        chk("t2_we_low", wr_lo, 32'd2);
        chk("t2_we_first", wr_first, 32'd3);
        chk("t2_ack_cycle", ack_cyc, 32'd6);
        chk1("t2_stable", stable, 1'b1);
        chk("t2_rdata1_kept", bus.p1_rdata, 32'h0);
        @(negedge clk);

        // both ports reading continuously from reset
        do_reset();
        bus.p0_we = 1'b0; bus.p0_addr = 16'h0100;
        bus.p1_we = 1'b0; bus.p1_addr = 16'h0200;
        bus.p0_req = 1'b1; bus.p1_req = 1'b1;
        prev_ack = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (prev_ack) chk1("t3_gap", bus.busy, 1'b0);
            prev_ack = bus.p0_ack | bus.p1_ack;
            if (bus.p0_ack) order.push_back(0);
            if (bus.p1_ack) order.push_back(1);
        end
        for (int i = 0; i < 4; i++)
            chk("t3_order", (i < order.size()) ? order[i] : 32'd9, i % 2);
        chk("t3_rdata0", bus.p0_rdata, 32'hC2C30100);
        chk("t3_rdata1", bus.p1_rdata, 32'hC1C30200);
        bus.p0_req = 1'b0; bus.p1_req = 1'b0;
        repeat (6) @(negedge clk);

        // PROGRAM blocks port 1
        bus.PROGRAM = 1'b1;
        bus.p1_we = 1'b0; bus.p1_addr = 16'h0030; bus.p1_req = 1'b1;
        busy_cnt = 0; ack_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            busy_cnt += int'(bus.busy);
            ack_cnt  += int'(bus.p1_ack);
        end
        chk("t4_busy", busy_cnt, 32'd0);
        chk("t4_ack", ack_cnt, 32'd0);
        bus.PROGRAM = 1'b0;
        @(negedge clk);
        chk1("t4_served", bus.busy, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            found = bus.p1_ack;
        end
        chk1("t4_acked", found, 1'b1);
        chk("t4_rdata1", bus.p1_rdata, 32'hC3F30030);
        bus.p1_req = 1'b0;
        @(negedge clk);

        // reset during the write pulse
        bus.p0_we = 1'b1; bus.p0_addr = 16'h0040; bus.p0_wdata = 32'h11223344; bus.p0_req = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            found = !bus.webar_chip;
        end
        chk1("t5_in_pulse", found, 1'b1);
        areset = 1'b1;
        bus.p0_req = 1'b0;
        @(negedge clk);
        chk1("t5_webar", bus.webar_chip, 1'b1);
        chk1("t5_oe", bus.mdata_oe_chip, 1'b1);
        chk1("t5_busy", bus.busy, 1'b0);
        chk1("t5_no_ack", bus.p0_ack, 1'b0);
        areset = 1'b0;
        @(negedge clk);
        run_txn(1'b0, 1'b0, 16'h0020, 32'h0, ack_cyc, rd_lo, oe_lo, oe_first, wr_lo, wr_first, stable);
        chk("t5_ack_cycle", ack_cyc, 32'd4);
        chk("t5_rdata", bus.p0_rdata, 32'hC3E30020);
        @(negedge clk);

        // random traffic, including requests dropped before their ack
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                bus.p0_req = 1'($urandom_range(0, 1)); bus.p0_we = 1'($urandom_range(0, 1));
                bus.p0_addr = 16'($urandom); bus.p0_wdata = $urandom;
            end
            if ($urandom_range(0, 3) == 0) begin
                bus.p1_req = 1'($urandom_range(0, 1)); bus.p1_we = 1'($urandom_range(0, 1));
                bus.p1_addr = 16'($urandom); bus.p1_wdata = $urandom;
            end
            if ($urandom_range(0, 15) == 0) bus.PROGRAM = !bus.PROGRAM;
        end
        bus.p0_req = 1'b0; bus.p1_req = 1'b0; bus.PROGRAM = 1'b0;
        repeat (20) @(negedge clk);
        chk1("end_idle", bus.busy, 1'b0);
        chk("ack_per_grant", dut_acks, m_acks);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
